// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - round-robin sequencer sharing one tx_module among NUM_REQ byte requesters
// Optional grant lock across frames: define TX_ARB_LOCK_EN.
module tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int GAP_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [GAP_W-1:0]            gap_cycles_i,
  input  logic [TIMEOUT_W-1:0]        timeout_cycles_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_lock_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        tx_en_o,
  output logic                        tx_start_o,
  output logic [DATA_W-1:0]           tx_data_o,
  input  logic                        tx_done_i,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic [IDX_W-1:0]       rr_next;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_ok;
  logic                   hold_active;
  logic                   accept;
  logic [NUM_REQ-1:0]     sel_onehot;
  logic [GAP_W-1:0]       gap_cnt;
  logic [GAP_W:0]         gap_next;
  logic                   gap_last;
  logic [TIMEOUT_W-1:0]   wd_cnt;
  logic                   timeout_hit;
  logic [IDX_W:0]         scan;

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_REQ))
        scan = scan - (IDX_W+1)'(NUM_REQ);
      if (!win_found && req_valid_i[scan[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDX_W-1:0];
      end
    end
  end

  assign rr_next = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

`ifdef TX_ARB_LOCK_EN
  logic             lock_hold;
  logic [IDX_W-1:0] owner_idx;

  assign hold_active = lock_hold & req_lock_i[owner_idx];
  assign sel_idx     = hold_active ? owner_idx : win_idx;
  assign sel_ok      = hold_active ? req_valid_i[owner_idx] : win_found;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lock_hold <= 1'b0;
      owner_idx <= '0;
    end else begin
      if (accept) begin
        owner_idx <= sel_idx;
        if (!hold_active)
          lock_hold <= 1'b0;
      end else if (timeout_hit) begin
        lock_hold <= 1'b0;
      end else if ((state == WAIT_DONE && tx_done_i && gap_cycles_i == '0) ||
                   (state == GAP && gap_last)) begin
        lock_hold <= req_lock_i[owner_idx];
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign hold_active = 1'b0;
  assign sel_idx     = win_idx;
  assign sel_ok      = win_found;
`endif

  // Ready is gated by rst_i so nothing is accepted while reset is asserted.
  assign accept      = rst_i & (state == IDLE) & enable_i & sel_ok;
  assign sel_onehot  = NUM_REQ'(1) << sel_idx;
  assign req_ready_o = accept ? sel_onehot : '0;
  assign busy_o      = (state != IDLE);

  assign gap_next    = {1'b0, gap_cnt} + {{GAP_W{1'b0}}, 1'b1};
  assign gap_last    = (gap_next >= {1'b0, gap_cycles_i});
  assign timeout_hit = (state == WAIT_DONE) && !tx_done_i &&
                       (timeout_cycles_i != '0) &&
                       (wd_cnt == timeout_cycles_i - 1'b1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant_o    <= '0;
      tx_en_o    <= 1'b0;
      tx_start_o <= 1'b0;
      tx_data_o  <= '0;
      timeout_o  <= 1'b0;
      gap_cnt    <= '0;
      wd_cnt     <= '0;
    end else begin
      tx_en_o    <= enable_i;
      tx_start_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data_o  <= req_data_i[int'(sel_idx)*DATA_W +: DATA_W];
            grant_o    <= sel_onehot;
            tx_start_o <= 1'b1;
            if (!hold_active)
              rr_ptr <= rr_next;
            state <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done_i) begin
            grant_o <= '0;
            gap_cnt <= '0;
            state   <= (gap_cycles_i != '0) ? GAP : IDLE;
          end else if (timeout_hit) begin
            grant_o   <= '0;
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_last)
            state <= IDLE;
          else if (gap_cnt != '1)
            gap_cnt <= gap_next[GAP_W-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - directed self-checking bench for tx_arbiter
module tb_tx_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [7:0]  gap_cycles_i;
  logic [15:0] timeout_cycles_i;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_lock_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic        tx_en_o;
  logic        tx_start_o;
  logic [7:0]  tx_data_o;
  logic        tx_done_i;
  logic        busy_o;
  logic        timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_W(8), .TIMEOUT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .gap_cycles_i(gap_cycles_i), .timeout_cycles_i(timeout_cycles_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_lock_i(req_lock_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .tx_en_o(tx_en_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_done_i(tx_done_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the arbiter in IDLE; runs one frame with gap 0.
  task automatic frame(input string tag, input logic [3:0] exp_oh, input logic [7:0] exp_data,
                       input logic [3:0] nv, input logic [31:0] nd, input logic [3:0] nl);
    #1 check({tag, "_ready"}, req_ready_o, exp_oh);
    @(negedge clk_i);
    check({tag, "_start"}, tx_start_o, 1'b1);
    check({tag, "_grant"}, grant_o, exp_oh);
    check({tag, "_data"}, tx_data_o, exp_data);
    req_valid_i = nv;
    req_data_i  = nd;
    req_lock_i  = nl;
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] oh;
    logic [7:0] ed;

    rst_i = 1'b0; enable_i = 1'b0; gap_cycles_i = 8'd0; timeout_cycles_i = 16'd0;
    req_valid_i = 4'b0; req_data_i = 32'h0; req_lock_i = 4'b0; tx_done_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_ready", req_ready_o, 4'b0);
    check("rst_grant", grant_o, 4'b0);
    check("rst_tx_en", tx_en_o, 1'b0);
    check("rst_start", tx_start_o, 1'b0);
    check("rst_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);

    rst_i = 1'b1;
    enable_i = 1'b1;
    @(negedge clk_i);
    check("tx_en_follow", tx_en_o, 1'b1);

    // Fairness: all four valid, grant order 0,1,2,3,0
    req_data_i  = 32'h13121110;
    req_valid_i = 4'hf;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      ed = 8'h10 + 8'(i % 4);
      frame("fair", oh, ed, (i == 4) ? 4'h0 : 4'hf, 32'h13121110, 4'h0);
    end

    // Single request from requester 2 (rr pointer now 1)
    req_data_i  = 32'h00AA0000;
    req_valid_i = 4'b0100;
    #1 check("single_ready", req_ready_o, 4'b0100);
    @(negedge clk_i);
    check("single_ready_pulse", req_ready_o, 4'b0000);
    check("single_start", tx_start_o, 1'b1);
    check("single_data", tx_data_o, 8'hAA);
    check("single_grant", grant_o, 4'b0100);
    check("single_busy", busy_o, 1'b1);
    req_valid_i = 4'b0;
    @(negedge clk_i);
    check("single_start_1cyc", tx_start_o, 1'b0);
    repeat (3) @(negedge clk_i);
    check("single_grant_hold", grant_o, 4'b0100);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("single_idle_busy", busy_o, 1'b0);
    check("single_idle_grant", grant_o, 4'b0);
    check("single_data_held", tx_data_o, 8'hAA);

    // Stray tx_done while idle is ignored
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("stray_done_busy", busy_o, 1'b0);
    check("stray_done_start", tx_start_o, 1'b0);

    // Gap of 5: done -> 5 GAP cycles -> 1 IDLE -> tx_start
    gap_cycles_i = 8'd5;
    req_data_i   = 32'h0000B1B0;
    req_valid_i  = 4'b0011;
    #1 check("gap_ready0", req_ready_o, 4'b0001);
    @(negedge clk_i);
    check("gap_data0", tx_data_o, 8'hB0);
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("gap_grant_clr", grant_o, 4'b0);
    check("gap_busy1", busy_o, 1'b1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk_i);
      check("gap_busy", busy_o, 1'b1);
      check("gap_no_ready", req_ready_o, 4'b0);
    end
    @(negedge clk_i);
    check("gap_idle_busy", busy_o, 1'b0);
    check("gap_idle_ready", req_ready_o, 4'b0010);
    @(negedge clk_i);
    check("gap_start1", tx_start_o, 1'b1);
    check("gap_data1", tx_data_o, 8'hB1);
    req_valid_i = 4'b0;
    @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    gap_cycles_i = 8'd0;
    repeat (8) @(negedge clk_i);
    check("gap_end_busy", busy_o, 1'b0);

    // Watchdog at 100 (rr pointer now 2): requester 3 times out, requester 0 served next
    timeout_cycles_i = 16'd100;
    req_data_i  = 32'hC30000C0;
    req_valid_i = 4'b1001;
    #1 check("wd_ready3", req_ready_o, 4'b1000);
    @(negedge clk_i);
    check("wd_start3", tx_start_o, 1'b1);
    req_valid_i = 4'b0001;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (timeout_o !== 1'b1 && n < 200);
    check("wd_latency", n, 101);
    check("wd_grant_clr", grant_o, 4'b0);
    check("wd_busy", busy_o, 1'b0);
    check("wd_next_ready", req_ready_o, 4'b0001);
    @(negedge clk_i);
    check("wd_pulse_1cyc", timeout_o, 1'b0);
    check("wd_next_start", tx_start_o, 1'b1);
    check("wd_next_data", tx_data_o, 8'hC0);
    req_valid_i = 4'b0;
    // tx_done on the very cycle the watchdog would fire: done wins
    repeat (100) @(negedge clk_i);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("wd_tie_no_timeout", timeout_o, 1'b0);
    check("wd_tie_busy", busy_o, 1'b0);
    timeout_cycles_i = 16'd0;

    // Enable dropped mid-frame: frame finishes, no further grant
    req_data_i  = 32'hD3D20000;
    req_valid_i = 4'b0100;
    #1 check("en_ready", req_ready_o, 4'b0100);
    @(negedge clk_i);
    check("en_start", tx_start_o, 1'b1);
    req_valid_i = 4'b1000;
    #1 check("en_no_ready_busy", req_ready_o, 4'b0);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("en_tx_en_low", tx_en_o, 1'b0);
    check("en_busy", busy_o, 1'b1);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    check("en_done_busy", busy_o, 1'b0);
    check("en_no_grant", req_ready_o, 4'b0);
    @(negedge clk_i);
    check("en_still_idle", busy_o, 1'b0);
    req_valid_i = 4'b0;
    enable_i = 1'b1;
    @(negedge clk_i);

    // Async reset in WAIT_DONE (rr pointer now 3)
    req_data_i  = 32'hE3E2E1E0;
    req_valid_i = 4'b1000;
    #1 check("ar_ready", req_ready_o, 4'b1000);
    @(negedge clk_i);
    req_valid_i = 4'b0;
    @(negedge clk_i);
    check("ar_pre_busy", busy_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    check("ar_grant", grant_o, 4'b0);
    check("ar_busy", busy_o, 1'b0);
    check("ar_data", tx_data_o, 8'h00);
    check("ar_tx_en", tx_en_o, 1'b0);
    check("ar_start", tx_start_o, 1'b0);
    req_valid_i = 4'hf;
    #1 check("ar_ready_in_rst", req_ready_o, 4'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    frame("ar_first", 4'b0001, 8'hE0, 4'h0, 32'hE3E2E1E0, 4'h0);

`ifdef TX_ARB_LOCK_EN
    // Requester 1 locked for three bytes while requester 3 waits
    req_lock_i  = 4'b0010;
    req_valid_i = 4'b1010;
    req_data_i  = {8'hC3, 8'h00, 8'hA1, 8'h00};
    frame("lock1", 4'b0010, 8'hA1, 4'b1010, {8'hC3, 8'h00, 8'hA2, 8'h00}, 4'b0010);
    frame("lock2", 4'b0010, 8'hA2, 4'b1010, {8'hC3, 8'h00, 8'hA3, 8'h00}, 4'b0010);
    frame("lock3", 4'b0010, 8'hA3, 4'b1000, {8'hC3, 8'h00, 8'hA3, 8'h00}, 4'b0000);
    frame("lock4", 4'b1000, 8'hC3, 4'b0000, 32'h0, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one tx_module among NUM_REQ byte requesters.
- Per requester: valid/ready handshake. Toward tx_module: drives tx_en/tx_start/tx_data, waits for tx_done, inserts a programmable inter-frame gap.
- Watchdog aborts a frame when tx_done never arrives.
- Sits between requester logic (register block, loopback, FIFOs) and the tx_module instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; matches tx_module MAX_UART_DATA_W.
- GAP_W, 8, width of gap_cycles_i.
- TIMEOUT_W, 16, width of watchdog counter and timeout_cycles_i.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- enable_i  in  1  arbiter enable; drives tx_en_o.
- gap_cycles_i  in  GAP_W  idle clk cycles between frames; 0 = no gap.
- timeout_cycles_i  in  TIMEOUT_W  watchdog limit in clk cycles; 0 = watchdog disabled.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W].
- req_lock_i  in  NUM_REQ  hold grant across frames (used only with TX_ARB_LOCK_EN).
- req_ready_o  out  NUM_REQ  one-hot accept pulse.
- grant_o  out  NUM_REQ  one-hot owner of the current frame.
- tx_en_o  out  1  to tx_module tx_en_i.
- tx_start_o  out  1  one-cycle start pulse to tx_module.
- tx_data_o  out  DATA_W  registered byte to tx_module tx_data_i.
- tx_done_i  in  1  tx_module tx_done_o.
- busy_o  out  1  high when not in IDLE.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (rst_i=0, async): state=IDLE, rr pointer=0, all outputs 0, tx_data_o=0, counters=0.
- tx_en_o = registered enable_i (1-cycle delay).
- States: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If enable_i=1 and any req_valid_i, pick the winner: first valid index at or above the rr pointer, wrapping modulo NUM_REQ.
  - Drive req_ready_o[winner]=1 combinationally in that same cycle.
  - Latch req_data_i slice into tx_data_o; set grant_o to the winner's one-hot.
  - Set rr pointer = (winner+1) mod NUM_REQ; go to START.
  - Otherwise stay in IDLE, no ready.
- START: tx_start_o=1 for exactly 1 cycle; clear watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - On tx_done_i=1, go to GAP if gap_cycles_i>0, else IDLE.
  - If timeout_cycles_i!=0 and the count reaches timeout_cycles_i-1 without tx_done_i: pulse timeout_o, go to IDLE with no gap.
  - tx_done_i and timeout in the same cycle: done wins, no timeout_o.
- GAP: count gap_cycles_i cycles, then IDLE; grant_o cleared on entry to GAP.
- grant_o is held from START through WAIT_DONE.
- Handshake: requester holds req_valid_i and data stable until ready. Exactly one req_ready_o bit high per accepted byte. Accept-to-tx_start_o latency is 1 cycle. Back-to-back min spacing = tx frame + gap + 1 IDLE cycle.
- tx_done_i outside WAIT_DONE is ignored.
- enable_i deasserted mid-frame: current frame completes; no new grant afterwards.
- A requester dropping valid before ready: no effect. The arbiter never captures a byte without a ready pulse.
- Counters saturate and never wrap; the gap counter is GAP_W bits, the watchdog TIMEOUT_W bits.

Optional Feature:
- Macro: TX_ARB_LOCK_EN.
- Defined: if the current owner has req_lock_i=1 at return to IDLE, arbitration is bypassed. The owner is accepted again when its req_valid_i=1, and the rr pointer is not advanced.
  - If the owner's valid is low while lock is held, the arbiter waits in IDLE.
  - A timeout clears the lock hold.
- Not defined: req_lock_i ignored; pure round-robin.

Test Plan:
- Single request: NUM_REQ=4, req 2 valid, data 8'hAA, gap=0, timeout=0.
  -> req_ready_o=4'b0100 for 1 cycle; tx_start_o 1 cycle later; tx_data_o=8'hAA; grant_o=4'b0100 until tx_done_i; then IDLE.
- Fairness: all 4 valid continuously, distinct bytes 8'h10..8'h13.
  -> grant order 0,1,2,3,0; each byte sent once per round.
- Gap: gap_cycles_i=5, two back-to-back requests.
  -> exactly 5 GAP cycles + 1 IDLE between tx_done_i and the next tx_start_o.
- Watchdog: timeout_cycles_i=100, tx_done_i held 0.
  -> timeout_o pulses at cycle 100 after START; return to IDLE; next requester served.
- Async reset mid-frame: assert rst_i=0 during WAIT_DONE.
  -> all outputs 0 immediately; rr pointer=0; after release, requester 0 wins first.
- With TX_ARB_LOCK_EN: req 1 lock=1, 3 bytes, req 3 also valid.
  -> all 3 req 1 bytes are sent consecutively before req 3 is granted.
